// File: rtl/gamepad_pmod_multi_rx.sv
// gamepad_pmod_multi_rx: N-pad Gamepad Pmod receiver with frame-length checking, stale-link timeout and press/release pulses.
// Define GAMEPAD_PMOD_DEBOUNCE_EN to commit a frame only after two consecutive valid frames match.
module gamepad_pmod_multi_rx #(
  parameter int NUM_PADS       = 2,
  parameter int BUTTONS        = 12,
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 1048576
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          pmod_data,
  input  logic                          pmod_clk,
  input  logic                          pmod_latch,
  output logic [NUM_PADS*BUTTONS-1:0]   buttons,
  output logic [NUM_PADS-1:0]           is_present,
  output logic [NUM_PADS*BUTTONS-1:0]   pressed,
  output logic [NUM_PADS*BUTTONS-1:0]   released,
  output logic                          frame_valid,
  output logic                          frame_error,
  output logic                          link_up
);
  localparam int W  = NUM_PADS * BUTTONS;
  localparam int CW = $clog2(W + 2);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [2:0]          sync_q [SYNC_STAGES];
  logic [2:0]          dly_q;
  logic [W-1:0]        shift_q, shift_d, sh, raw_q, raw_d, cand, dec;
  logic [CW-1:0]       cnt_q, cnt_d, cnt;
  logic [TW-1:0]       tmo_q, tmo_d;
  logic [NUM_PADS-1:0] pres;
  logic                clk_rise, lat_rise, valid, error, commit, timeout;
  // Sync vector bit order: {latch, clk, data}
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
      dly_q <= '0;
    end else begin
      sync_q[0] <= {pmod_latch, pmod_clk, pmod_data};
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      dly_q <= sync_q[SYNC_STAGES-1];
    end
  end
  assign clk_rise = sync_q[SYNC_STAGES-1][1] & ~dly_q[1];
  assign lat_rise = sync_q[SYNC_STAGES-1][2] & ~dly_q[2];
  // A coincident clk edge is folded into sh/cnt before the latch looks at them
  always_comb begin
    sh    = clk_rise ? {shift_q[W-2:0], sync_q[SYNC_STAGES-1][0]} : shift_q;
    cnt   = (clk_rise && cnt_q != CW'(W + 1)) ? cnt_q + 1'b1 : cnt_q;
    valid = 1'b0;
    cand  = '1;
    dec   = '0;
    pres  = '0;
    for (int k = 1; k <= NUM_PADS; k++)
      if (lat_rise && cnt == CW'(k * BUTTONS)) valid = 1'b1;
    for (int p = 0; p < NUM_PADS; p++) begin
      cand[p*BUTTONS +: BUTTONS] = (cnt >= CW'((p + 1) * BUTTONS)) ? sh[p*BUTTONS +: BUTTONS] : '1;
      dec[p*BUTTONS +: BUTTONS]  = &raw_q[p*BUTTONS +: BUTTONS] ? '0 : raw_q[p*BUTTONS +: BUTTONS];
      pres[p]                    = ~&raw_q[p*BUTTONS +: BUTTONS];
    end
    error   = lat_rise & ~valid;
    shift_d = lat_rise ? '1 : sh;
    cnt_d   = lat_rise ? '0 : cnt;
    timeout = !valid && tmo_q == TW'(TIMEOUT_CYCLES - 1);
    tmo_d   = valid ? '0 : (tmo_q == TW'(TIMEOUT_CYCLES) ? tmo_q : tmo_q + 1'b1);
    raw_d   = timeout ? '1 : (commit ? cand : raw_q);
  end
`ifdef GAMEPAD_PMOD_DEBOUNCE_EN
  logic [W-1:0] prev_q;
  logic         have_q;
  assign commit = valid && have_q && cand == prev_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_q <= '1;
      have_q <= 1'b0;
    end else if (valid) begin
      prev_q <= cand;
      have_q <= 1'b1;
    end else if (error) begin
      have_q <= 1'b0;
    end
  end
`else
  assign commit = valid;
`endif
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shift_q     <= '1;
      raw_q       <= '1;
      cnt_q       <= '0;
      tmo_q       <= '0;
      buttons     <= '0;
      is_present  <= '0;
      pressed     <= '0;
      released    <= '0;
      frame_valid <= 1'b0;
      frame_error <= 1'b0;
      link_up     <= 1'b0;
    end else begin
      shift_q     <= shift_d;
      raw_q       <= raw_d;
      cnt_q       <= cnt_d;
      tmo_q       <= tmo_d;
      buttons     <= dec;
      is_present  <= pres;
      pressed     <= dec & ~buttons;
      released    <= ~dec & buttons;
      frame_valid <= valid;
      frame_error <= error;
      link_up     <= valid ? 1'b1 : (timeout ? 1'b0 : link_up);
    end
  end
endmodule

// File: tb/tb_gamepad_pmod_multi_rx.sv
// tb_gamepad_pmod_multi_rx: scoreboard bench for gamepad_pmod_multi_rx (2 pads x 12 buttons, 64-cycle timeout).
module tb_gamepad_pmod_multi_rx;
  localparam int NP = 2;
  localparam int B = 12;
  localparam int W = NP * B;
  localparam int TMO = 64;
  logic clk = 1'b0, rst = 1'b1, pmod_data = 1'b0, pmod_clk = 1'b0, pmod_latch = 1'b0;
  logic [W-1:0] buttons, pressed, released;
  logic [NP-1:0] is_present;
  logic frame_valid, frame_error, link_up;
  int tests = 0, fails = 0;
  typedef struct {
    bit err;
    logic [W-1:0] btn;
    logic [NP-1:0] pres;
    logic [W-1:0] prs;
    logic [W-1:0] rel;
  } exp_t;
  exp_t q[$];
  exp_t cur;
  bit chk_pending = 0;
  logic [W-1:0] mdl_raw = '1;
  logic [W-1:0] mdl_prev = '1;
  bit mdl_have = 0;

  gamepad_pmod_multi_rx #(.NUM_PADS(NP), .BUTTONS(B), .SYNC_STAGES(2), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst(rst), .pmod_data(pmod_data), .pmod_clk(pmod_clk), .pmod_latch(pmod_latch),
    .buttons(buttons), .is_present(is_present), .pressed(pressed), .released(released),
    .frame_valid(frame_valid), .frame_error(frame_error), .link_up(link_up));

  always #5 clk = ~clk;

  function automatic logic [W-1:0] dec_btn(input logic [W-1:0] r);
    logic [W-1:0] d = '0;
    for (int p = 0; p < NP; p++) d[p*B +: B] = (r[p*B +: B] == {B{1'b1}}) ? '0 : r[p*B +: B];
    return d;
  endfunction

  function automatic logic [NP-1:0] dec_pres(input logic [W-1:0] r);
    logic [NP-1:0] d = '0;
    for (int p = 0; p < NP; p++) d[p] = (r[p*B +: B] != {B{1'b1}});
    return d;
  endfunction

  function automatic void model_frame(input logic [31:0] v, input int n);
    exp_t e;
    logic [W-1:0] r = mdl_raw;
    logic [W-1:0] c = '1;
    logic [W-1:0] old = dec_btn(mdl_raw);
    e.err = !(n >= B && n <= W && n % B == 0);
    if (!e.err) begin
      for (int p = 0; p < NP; p++) if (p < n / B) c[p*B +: B] = v[p*B +: B];
`ifdef GAMEPAD_PMOD_DEBOUNCE_EN
      if (mdl_have && c == mdl_prev) r = c;
      mdl_prev = c;
      mdl_have = 1;
`else
      r = c;
`endif
    end else begin
`ifdef GAMEPAD_PMOD_DEBOUNCE_EN
      mdl_have = 0;
`endif
    end
    e.btn = dec_btn(r);
    e.pres = dec_pres(r);
    e.prs = e.btn & ~old;
    e.rel = ~e.btn & old;
    mdl_raw = r;
    q.push_back(e);
  endfunction

  // Scoreboard monitor: each frame pulse pops one expectation; outputs are checked one cycle later
  always @(negedge clk) begin
    if (rst) chk_pending = 0;
    else begin
      if (chk_pending) begin
        chk_pending = 0;
        tests++;
        if (buttons !== cur.btn || is_present !== cur.pres || pressed !== cur.prs || released !== cur.rel) begin
          fails++;
          $display("FAIL frame_outputs: got buttons=%h present=%b pressed=%h released=%h, want %h %b %h %h",
                   buttons, is_present, pressed, released, cur.btn, cur.pres, cur.prs, cur.rel);
        end
      end
      if (frame_valid || frame_error) begin
        tests++;
        if (q.size() == 0) begin
          fails++;
          $display("FAIL unexpected_pulse: got valid=%b error=%b, want no pulse", frame_valid, frame_error);
        end else begin
          cur = q.pop_front();
          if (frame_error !== cur.err || frame_valid !== !cur.err) begin
            fails++;
            $display("FAIL frame_kind: got valid=%b error=%b, want error=%b", frame_valid, frame_error, cur.err);
          end
          chk_pending = 1;
        end
      end
    end
  end

  task automatic send_frame(input logic [31:0] v, input int n, input bit latch);
    for (int i = n - 1; i >= 0; i--) begin
      pmod_data = v[i];
      pmod_clk = 1'b1;
      @(negedge clk);
      pmod_clk = 1'b0;
      @(negedge clk);
    end
    if (latch) begin
      model_frame(v, n);
      pmod_latch = 1'b1;
      @(negedge clk);
      pmod_latch = 1'b0;
      @(negedge clk);
    end
  endtask

  task automatic drain();
    int t = 0;
    while ((q.size() != 0 || chk_pending) && t < 40) begin
      @(negedge clk);
      t++;
    end
    tests++;
    if (t >= 40) begin
      fails++;
      $display("FAIL drain_timeout: got %0d frames outstanding, want 0", q.size());
      q.delete();
    end
    @(negedge clk);
  endtask

  task automatic idle_down();
    int t = 0;
    while (link_up && t < 300) begin
      @(negedge clk);
      t++;
    end
    tests++;
    if (link_up !== 1'b0) begin
      fails++;
      $display("FAIL idle_link_down: got link_up=%b, want 0", link_up);
    end
    repeat (3) @(negedge clk);
    mdl_raw = '1;
  endtask

  task automatic test_reset();
    tests++;
    if ({buttons, is_present, pressed, released, frame_valid, frame_error, link_up} !== '0) begin
      fails++;
      $display("FAIL reset_hold: got buttons=%h present=%b link=%b, want all 0", buttons, is_present, link_up);
    end
    rst = 1'b0;
    repeat (2) @(negedge clk);
    tests++;
    if ({buttons, is_present, pressed, released, frame_valid, frame_error, link_up} !== '0) begin
      fails++;
      $display("FAIL reset_release: got buttons=%h present=%b link=%b, want all 0", buttons, is_present, link_up);
    end
  endtask

  task automatic test_full_and_partial();
    idle_down();
    send_frame(32'h003801, 24, 1);
    drain();
    tests++;
    if (pressed !== '0 || link_up !== 1'b1) begin
      fails++;
      $display("FAIL pulse_width: got pressed=%h link=%b, want 0 and 1", pressed, link_up);
    end
    send_frame(32'h010, 12, 1);
    drain();
    tests++;
    if (released !== '0 || is_present !== 2'b01) begin
      fails++;
      $display("FAIL partial_after: got released=%h present=%b, want 0 and 01", released, is_present);
    end
  endtask

  task automatic test_errors();
    idle_down();
    send_frame(32'h5A5, 12, 1);
    drain();
    send_frame(32'h0, 0, 1);
    drain();
    send_frame(32'h0ABC, 13, 1);
    drain();
    tests++;
    if (buttons !== 24'h0005A5 || is_present !== 2'b01) begin
      fails++;
      $display("FAIL error_keeps: got buttons=%h present=%b, want 0005a5 01", buttons, is_present);
    end
  endtask

  task automatic test_timeout();
    int t = 0, hi = 0;
    logic [W-1:0] old;
    idle_down();
    send_frame(32'h0C33C0, 24, 1);
    while (!link_up && t < 20) begin
      @(negedge clk);
      t++;
    end
    while (link_up && hi < 200) begin
      hi++;
      @(negedge clk);
    end
    tests++;
    if (hi !== TMO) begin
      fails++;
      $display("FAIL link_up_duration: got %0d cycles, want %0d", hi, TMO);
    end
    old = dec_btn(mdl_raw);
    @(negedge clk);
    tests++;
    if (buttons !== '0 || is_present !== '0 || released !== old || pressed !== '0) begin
      fails++;
      $display("FAIL timeout_outputs: got buttons=%h present=%b released=%h, want 0 00 %h", buttons, is_present, released, old);
    end
    mdl_raw = '1;
    send_frame(32'h0F0, 12, 1);
    drain();
    tests++;
    if (link_up !== 1'b1) begin
      fails++;
      $display("FAIL link_restore: got link_up=%b, want 1", link_up);
    end
  endtask

  task automatic test_reset_mid();
    send_frame(32'h55, 7, 0);
    rst = 1'b1;
    @(negedge clk);
    tests++;
    if ({buttons, is_present, pressed, released, frame_valid, frame_error, link_up} !== '0) begin
      fails++;
      $display("FAIL reset_mid: got buttons=%h present=%b link=%b, want all 0", buttons, is_present, link_up);
    end
    rst = 1'b0;
    mdl_raw = '1;
    mdl_prev = '1;
    mdl_have = 0;
    @(negedge clk);
    send_frame(32'h123456, 24, 1);
    drain();
  endtask

`ifdef GAMEPAD_PMOD_DEBOUNCE_EN
  task automatic test_debounce();
    idle_down();
    send_frame(32'h111, 12, 1);
    drain();
    send_frame(32'h222, 12, 1);
    drain();
    send_frame(32'h222, 12, 1);
    drain();
    tests++;
    if (buttons !== 24'h000222 || is_present !== 2'b01) begin
      fails++;
      $display("FAIL debounce_commit: got buttons=%h present=%b, want 000222 01", buttons, is_present);
    end
  endtask
`endif

  initial begin
    repeat (3) @(negedge clk);
    test_reset();
    test_full_and_partial();
    test_errors();
    test_timeout();
    test_reset_mid();
`ifdef GAMEPAD_PMOD_DEBOUNCE_EN
    test_debounce();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion, want finish");
    $fatal(1, "watchdog");
  end
endmodule
